// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit that owns the HI/LO registers; radix-2 shift-add multiply, restoring divide.
// Optional MADD/MSUB accumulate ops are compiled in when MULDIV_ACC_EN is defined.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             startE,
   input  logic [2:0]       opE,
   input  logic [WIDTH-1:0] srcaE,
   input  logic [WIDTH-1:0] srcbE,
   input  logic             flushE,
   input  logic             hireadD,
   input  logic             loreadD,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stallD
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

   state_t state, state_n;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opb;
   logic               is_div, is_acc, is_sub, neg_lo, neg_hi, div_zero;

   logic               op_ok, accept, mt_write, signed_op;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum, div_rs, div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] mul_next, div_next, p_fix;
   logic [WIDTH-1:0]   q_fix, r_fix;

`ifdef MULDIV_ACC_EN
   assign op_ok = (opE[2:1] != 2'b10);
`else
   assign op_ok = ~opE[2];
`endif

   assign accept    = (state == IDLE) & startE & ~flushE & op_ok;
   assign mt_write  = (state == IDLE) & startE & ~flushE & (opE[2:1] == 2'b10);
   assign signed_op = opE[2] | ~opE[0];
   assign mag_a     = (signed_op & srcaE[WIDTH-1]) ? -srcaE : srcaE;
   assign mag_b     = (signed_op & srcbE[WIDTH-1]) ? -srcbE : srcbE;

   // Multiply: lower half holds the remaining multiplier bits, upper half the partial sum.
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};

   // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
   assign div_rs   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_diff = div_rs - {1'b0, opb};
   assign div_ge   = ~div_diff[WIDTH];
   assign div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_rs[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

   assign p_fix = neg_lo ? -acc : acc;
   assign q_fix = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign r_fix = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   assign busy   = (state != IDLE);
   assign stallD = busy & (startE | hireadD | loreadD);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = ITER;
         ITER:    if (flushE) state_n = IDLE;
                  else if (cnt == LAST) state_n = FIX;
         FIX:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi       <= '0;
         lo       <= '0;
         acc      <= '0;
         opb      <= '0;
         cnt      <= '0;
         is_div   <= 1'b0;
         is_acc   <= 1'b0;
         is_sub   <= 1'b0;
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
         div_zero <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            acc      <= {{WIDTH{1'b0}}, mag_a};
            opb      <= mag_b;
            cnt      <= '0;
            is_div   <= ~opE[2] & opE[1];
            is_acc   <= opE[2];
            is_sub   <= opE[0];
            neg_lo   <= signed_op & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
            neg_hi   <= signed_op & srcaE[WIDTH-1];
            div_zero <= (srcbE == '0);
         end else if (mt_write) begin
            if (opE[0]) lo <= srcaE;
            else        hi <= srcaE;
         end else if (state == ITER && !flushE) begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + CW'(1);
         end else if (state == FIX && !flushE) begin
            done <= 1'b1;
            if (is_div) begin
               // Divide by zero must return the original dividend in HI and all ones in LO.
               lo <= div_zero ? '1 : q_fix;
               hi <= r_fix;
            end else if (is_acc) begin
               {hi, lo} <= is_sub ? ({hi, lo} - p_fix) : ({hi, lo} + p_fix);
            end else begin
               {hi, lo} <= p_fix;
            end
         end
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops push expected {hi,lo}; a monitor checks each done pulse.
module tb_muldiv_unit;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         startE, flushE, hireadD, loreadD;
   logic [2:0]   opE;
   logic [W-1:0] srcaE, srcbE;
   logic [W-1:0] hi, lo;
   logic         busy, done, stallD;

   logic [2*W-1:0] exp_q[$];
   int total_cnt = 0;
   int pass_cnt  = 0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .startE(startE), .opE(opE),
      .srcaE(srcaE), .srcbE(srcbE), .flushE(flushE),
      .hireadD(hireadD), .loreadD(loreadD),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .stallD(stallD)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && done) begin
         if (exp_q.size() == 0) check("unexpected_done", {hi, lo}, {2*W{1'bx}});
         else check("result", {hi, lo}, exp_q.pop_front());
      end
   end

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(posedge clk); #1;
      startE = 1'b1; opE = op; srcaE = a; srcbE = b;
      @(posedge clk); #1;
      startE = 1'b0;
   endtask

   // Counts clock edges until busy falls, starting just after the accept edge.
   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
      int n;
      exp_q.push_back({eh, el});
      issue(op, a, b);
      wait_idle(n);
      check({name, "_busy_cycles"}, 64'(n), 64'(W + 1));
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      reset = 1'b1; startE = 1'b0; flushE = 1'b0; hireadD = 1'b0; loreadD = 1'b0;
      opE = 3'b000; srcaE = '0; srcbE = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_hi", 64'(hi), 64'(0));
      check("reset_lo", 64'(lo), 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_done", 64'(done), 64'(0));
      reset = 1'b0;

      run_op("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("divu", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);
      run_op("div_neg_dividend", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_neg_divisor", 3'b010, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
      run_op("divu_zero", 3'b011, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
      run_op("div_zero_neg", 3'b010, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF);
      run_op("div_overflow", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

      // MTHI/MTLO write on the issuing edge with no busy period.
      issue(3'b100, 32'h1234, 32'd0);
      check("mthi_busy", 64'(busy), 64'(0));
      check("mthi_hi", 64'(hi), 64'(32'h1234));
      issue(3'b101, 32'hABCD, 32'd0);
      check("mtlo_lo", 64'(lo), 64'(32'hABCD));
      check("mtlo_hi", 64'(hi), 64'(32'h1234));

      // Reads in decode stall while busy; a second start mid-op is dropped.
      hireadD = 1'b1;
      @(posedge clk); #1;
      check("stall_idle", 64'(stallD), 64'(0));
      exp_q.push_back({32'd0, 32'd42});
      issue(3'b000, 32'd7, 32'd6);
      check("stall_read", 64'(stallD), 64'(1));
      repeat (5) @(posedge clk);
      #1;
      startE = 1'b1; opE = 3'b001; srcaE = 32'd1; srcbE = 32'd1;
      check("stall_start", 64'(stallD), 64'(1));
      @(posedge clk); #1;
      startE = 1'b0;
      check("stall_hold", 64'(stallD), 64'(1));
      wait_idle(n);
      check("stall_busy_cycles", 64'(n), 64'(W + 1 - 6));
      check("stall_released", 64'(stallD), 64'(0));
      hireadD = 1'b0;
      repeat (2) @(posedge clk);

      // Flush mid-divide: back to idle next edge, HI/LO untouched, no done.
      issue(3'b011, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      #1;
      flushE = 1'b1;
      @(posedge clk); #1;
      flushE = 1'b0;
      check("flush_busy", 64'(busy), 64'(0));
      repeat (40) @(posedge clk);
      #1;
      check("flush_hilo", {hi, lo}, {32'd0, 32'd42});

      // Start together with flush in idle is not accepted.
      @(posedge clk); #1;
      startE = 1'b1; flushE = 1'b1; opE = 3'b000; srcaE = 32'd3; srcbE = 32'd3;
      @(posedge clk); #1;
      startE = 1'b0; flushE = 1'b0;
      check("flush_start_busy", 64'(busy), 64'(0));

      // Asynchronous reset in the middle of a multiply.
      issue(3'b001, 32'hFFFF_FFFF, 32'd3);
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("midop_reset_hilo", {hi, lo}, 64'd0);
      check("midop_reset_busy", 64'(busy), 64'(0));
      @(posedge clk); #1;
      reset = 1'b0;

      issue(3'b100, 32'd0, 32'd0);
      issue(3'b101, 32'd10, 32'd0);
`ifdef MULDIV_ACC_EN
      run_op("madd", 3'b110, 32'd3, 32'd4, 32'd0, 32'd22);
      run_op("msub", 3'b111, 32'd2, 32'd20, 32'hFFFF_FFFF, 32'hFFFF_FFEE);
`else
      issue(3'b110, 32'd3, 32'd4);
      check("madd_ignored_busy", 64'(busy), 64'(0));
      issue(3'b111, 32'd2, 32'd20);
      check("msub_ignored_busy", 64'(busy), 64'(0));
      repeat (40) @(posedge clk);
      #1;
      check("acc_ignored_hilo", {hi, lo}, {32'd0, 32'd10});
`endif

      repeat (5) @(posedge clk);
      #1;
      check("results_outstanding", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit owning the HI/LO architectural registers for the pipelined MIPS core.
- Sits beside the execute-stage ALU; driven from decode/execute controls; supplies HI/LO to the datapath and a stall request to the hazard logic.
- Generalises the fixed 32-bit HI/LO write path to WIDTH-bit operands; adds signed/unsigned multi-cycle MULT/DIV, MTHI/MTLO, flush, and optional accumulate modes.

Parameters:
- WIDTH, 32, operand and HI/LO register width; minimum 4.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- startE  in  1  request; op issued this cycle
- opE  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB
- srcaE  in  WIDTH  rs operand; dividend/multiplicand; MTHI/MTLO data
- srcbE  in  WIDTH  rt operand; divisor/multiplier
- flushE  in  1  cancel in-flight op
- hireadD  in  1  MFHI in decode
- loreadD  in  1  MFLO in decode
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  iteration in progress
- done  out  1  one-cycle pulse on result commit
- stallD  out  1  hazard stall request

Behaviour:
- Reset (asynchronous, any time incl. mid-op): hi=0, lo=0, busy=0, done=0, iteration counter=0, state IDLE; in-flight op discarded.
- States: IDLE, ITER, FIX.
- IDLE + startE + op MULT/MULTU/DIV/DIVU (or MADD/MSUB when enabled): latch operands; for signed ops latch magnitudes and result sign(s); busy=1 next cycle; go ITER.
- ITER: one radix-2 step per cycle (shift-add multiply; restoring divide); exactly WIDTH cycles; then FIX.
- FIX: one cycle; apply sign correction, accumulate if MADD/MSUB; commit hi/lo on that edge; done=1 for the following cycle; busy=0; back to IDLE.
- Latency: accepted at edge 0; hi/lo and done valid after edge WIDTH+1; busy high for exactly WIDTH+1 cycles.
- Multiply: {hi,lo} = full 2*WIDTH product; signed ops two's complement.
- Divide: lo = quotient, hi = remainder; truncate toward zero; remainder takes dividend sign.
- Divide by zero: hi = dividend (srcaE, unmodified), lo = all ones; full latency still taken.
- Signed overflow (MIN / -1): lo = MIN, hi = 0.
- MTHI/MTLO in IDLE: hi (or lo) = srcaE on the same edge; no busy, no done.
- startE while busy: ignored (not queued); stallD asserted.
- stallD = busy & (startE | hireadD | loreadD); combinational; 0 in IDLE. hi/lo read during FIX-commit cycle return the old value; stall covers it.
- flushE while busy: return to IDLE next edge; hi/lo unchanged; no done. flushE with startE in IDLE: op not accepted. flushE takes priority over commit in FIX.
- Undefined opcodes (110/111 without feature): treated as no-op, not accepted.

Optional Feature:
- Macro MULDIV_ACC_EN.
- Defined: opE 110 MADD gives {hi,lo} += signed product; 111 MSUB gives {hi,lo} -= signed product. Same latency WIDTH+1; accumulate applied in FIX from hi/lo values at commit time. 2*WIDTH wrap, no saturation.
- Undefined: 110/111 ignored; busy stays 0; hi/lo unchanged.

Test Plan:
- WIDTH=32, MULT srcaE=0xFFFFFFFD (-3), srcbE=5 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1; done one cycle; busy high 33 cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 -> lo=14, hi=2; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 5/0 -> hi=5, lo=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x1234 then MTLO 0xABCD in idle -> hi=0x1234, lo=0xABCD next cycle, busy=0. MULT in flight plus hireadD=1 -> stallD=1 until busy drops. Second startE mid-op ignored.
- flushE at cycle 10 of a DIV -> busy=0 next cycle, hi/lo retain prior values, no done. Reset asserted mid-MULT -> hi=lo=0 immediately.
- MULDIV_ACC_EN: hi=0, lo=10; MADD 3x4 -> lo=22; MSUB 2x20 -> hi=0xFFFFFFFF, lo=0xFFFFFFEE. Without macro: same stimulus leaves hi/lo unchanged.
